// File: rtl/sound_event_seq.sv
// -----------------------------------------------------------------------------
// sound_event_seq
//   Turns one-cycle game event strobes (paddle ping, wall pong, goal) into timed
//   tone bursts on the (sound, mute) command interface of the pong sound card.
//   Events are arbitrated by priority goal > pong > ping. One lower-or-equal
//   priority event can wait in a one-deep pending slot. A goal plays
//   GOAL_BEEPS beeps. Every beep or burst is followed by a silent gap.
//
// Ports
//   snd_clk  in   sound clock, all logic on posedge
//   rstn     in   asynchronous active-low reset
//   enable   in   0 = silence: abort current sound, clear pending, force IDLE
//   ev_ping  in   paddle-hit strobe (one cycle)
//   ev_pong  in   wall-hit strobe (one cycle)
//   ev_goal  in   goal strobe (one cycle)
//   sound    out  tone code: 0 none, 1 ping, 2 pong, 3 goal (registered)
//   mute     out  1 = sound card silent (registered)
//   busy     out  1 whenever the sequencer is not IDLE (registered)
// -----------------------------------------------------------------------------
module sound_event_seq #(
  parameter int PING_TICKS = 12000000,
  parameter int PONG_TICKS = 12000000,
  parameter int GOAL_TICKS = 6000000,
  parameter int GAP_TICKS  = 3000000,
  parameter int GOAL_BEEPS = 3
) (
  input  logic       snd_clk,
  input  logic       rstn,
  input  logic       enable,
  input  logic       ev_ping,
  input  logic       ev_pong,
  input  logic       ev_goal,
  output logic [1:0] sound,
  output logic       mute,
  output logic       busy
);

  localparam int MAX_PP    = (PING_TICKS > PONG_TICKS) ? PING_TICKS : PONG_TICKS;
  localparam int MAX_GG    = (GOAL_TICKS > GAP_TICKS) ? GOAL_TICKS : GAP_TICKS;
  localparam int MAX_TICKS = (MAX_PP > MAX_GG) ? MAX_PP : MAX_GG;
  localparam int CW        = $clog2(MAX_TICKS + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  // Tone codes double as priorities, so a plain unsigned compare arbitrates.
  localparam logic [1:0] CODE_NONE = 2'd0;
  localparam logic [1:0] CODE_PING = 2'd1;
  localparam logic [1:0] CODE_PONG = 2'd2;
  localparam logic [1:0] CODE_GOAL = 2'd3;

  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_TICKS - 1);
  localparam logic [3:0]    BEEP_LAST = 4'(GOAL_BEEPS);

  // Counter reload for a PLAY of the given tone; the count runs load..0.
  function automatic logic [CW-1:0] f_play_load(input logic [1:0] code);
    case (code)
      CODE_PING: f_play_load = CW'(PING_TICKS - 1);
      CODE_PONG: f_play_load = CW'(PONG_TICKS - 1);
      CODE_GOAL: f_play_load = CW'(GOAL_TICKS - 1);
      default:   f_play_load = {CW{1'b0}};
    endcase
  endfunction

  logic [1:0]    r_state;
  logic [1:0]    r_cur;
  logic [1:0]    r_pend;   // CODE_NONE means the pending slot is empty
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_beep;   // goal beeps started in the current goal sequence
  logic [1:0]    r_sound;
  logic          r_mute;
  logic          r_busy;

  logic [1:0]    w_ev;
  logic [1:0]    w_nxt_state;
  logic [1:0]    w_nxt_cur;
  logic [1:0]    w_nxt_pend;
  logic [CW-1:0] w_nxt_cnt;
  logic [3:0]    w_nxt_beep;
  logic [1:0]    w_merge_win;
  logic [1:0]    w_merge_keep;

  // Highest-priority strobe of this cycle; strobes are ignored while disabled.
  always_comb begin
    w_ev = CODE_NONE;
    if (!enable) begin
      w_ev = CODE_NONE;
    end else if (ev_goal) begin
      w_ev = CODE_GOAL;
    end else if (ev_pong) begin
      w_ev = CODE_PONG;
    end else if (ev_ping) begin
      w_ev = CODE_PING;
    end else begin
      w_ev = CODE_NONE;
    end
  end

  // Gap-expiry merge of the new event with the pending slot. An equal-priority
  // duplicate is absorbed rather than kept pending.
  always_comb begin
    w_merge_win  = r_pend;
    w_merge_keep = CODE_NONE;
    if (w_ev > r_pend) begin
      w_merge_win  = w_ev;
      w_merge_keep = r_pend;
    end else if (w_ev == r_pend) begin
      w_merge_win  = r_pend;
      w_merge_keep = CODE_NONE;
    end else begin
      w_merge_win  = r_pend;
      w_merge_keep = w_ev;
    end
  end

  // Next-state logic: arbitration, preemption, pending slot and counters.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cur   = r_cur;
    w_nxt_pend  = r_pend;
    w_nxt_beep  = r_beep;
    // Free-running countdown that saturates at zero.
    w_nxt_cnt   = (r_cnt != {CW{1'b0}}) ? (r_cnt - {{(CW-1){1'b0}}, 1'b1}) : {CW{1'b0}};

    if (!enable) begin
      w_nxt_state = ST_IDLE;
      w_nxt_cur   = CODE_NONE;
      w_nxt_pend  = CODE_NONE;
      w_nxt_cnt   = {CW{1'b0}};
      w_nxt_beep  = 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_ev != CODE_NONE) begin
            w_nxt_state = ST_PLAY;
            w_nxt_cur   = w_ev;
            w_nxt_cnt   = f_play_load(w_ev);
            w_nxt_beep  = (w_ev == CODE_GOAL) ? 4'd1 : 4'd0;
          end else begin
            w_nxt_cnt   = {CW{1'b0}};
          end
        end

        ST_PLAY: begin
          if (w_ev > r_cur) begin
            // Preempt: the interrupted sound is discarded, pending untouched.
            w_nxt_state = ST_PLAY;
            w_nxt_cur   = w_ev;
            w_nxt_cnt   = f_play_load(w_ev);
            w_nxt_beep  = (w_ev == CODE_GOAL) ? 4'd1 : 4'd0;
          end else begin
            if (w_ev > r_pend) begin
              w_nxt_pend = w_ev;
            end else begin
              w_nxt_pend = r_pend;
            end
            if (r_cnt == {CW{1'b0}}) begin
              w_nxt_state = ST_GAP;
              w_nxt_cnt   = GAP_LOAD;
            end else begin
              w_nxt_state = ST_PLAY;
            end
          end
        end

        ST_GAP: begin
          if (w_ev > r_cur) begin
            w_nxt_state = ST_PLAY;
            w_nxt_cur   = w_ev;
            w_nxt_cnt   = f_play_load(w_ev);
            w_nxt_beep  = (w_ev == CODE_GOAL) ? 4'd1 : 4'd0;
          end else if (r_cnt != {CW{1'b0}}) begin
            if (w_ev > r_pend) begin
              w_nxt_pend = w_ev;
            end else begin
              w_nxt_pend = r_pend;
            end
          end else if ((r_cur == CODE_GOAL) && (r_beep < BEEP_LAST)) begin
            // Next beep of the goal sequence; a same-cycle event can only pend.
            w_nxt_state = ST_PLAY;
            w_nxt_cnt   = f_play_load(CODE_GOAL);
            w_nxt_beep  = r_beep + 4'd1;
            if (w_ev > r_pend) begin
              w_nxt_pend = w_ev;
            end else begin
              w_nxt_pend = r_pend;
            end
          end else if (w_merge_win != CODE_NONE) begin
            w_nxt_state = ST_PLAY;
            w_nxt_cur   = w_merge_win;
            w_nxt_pend  = w_merge_keep;
            w_nxt_cnt   = f_play_load(w_merge_win);
            w_nxt_beep  = (w_merge_win == CODE_GOAL) ? 4'd1 : 4'd0;
          end else begin
            w_nxt_state = ST_IDLE;
            w_nxt_cur   = CODE_NONE;
            w_nxt_beep  = 4'd0;
          end
        end

        default: begin
          w_nxt_state = ST_IDLE;
          w_nxt_cur   = CODE_NONE;
          w_nxt_pend  = CODE_NONE;
          w_nxt_cnt   = {CW{1'b0}};
          w_nxt_beep  = 4'd0;
        end
      endcase
    end
  end

  // Sequencer state registers.
  always_ff @(posedge snd_clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_cur   <= CODE_NONE;
      r_pend  <= CODE_NONE;
      r_cnt   <= {CW{1'b0}};
      r_beep  <= 4'd0;
    end else begin
      r_state <= w_nxt_state;
      r_cur   <= w_nxt_cur;
      r_pend  <= w_nxt_pend;
      r_cnt   <= w_nxt_cnt;
      r_beep  <= w_nxt_beep;
    end
  end

  // Output registers follow the state one edge later, except that a disable
  // silences the card on the very next edge.
  always_ff @(posedge snd_clk or negedge rstn) begin
    if (!rstn) begin
      r_sound <= CODE_NONE;
      r_mute  <= 1'b1;
      r_busy  <= 1'b0;
    end else if (!enable) begin
      r_sound <= CODE_NONE;
      r_mute  <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_PLAY: begin
          r_sound <= r_cur;
          r_mute  <= 1'b0;
          r_busy  <= 1'b1;
        end
        ST_GAP: begin
          r_sound <= CODE_NONE;
          r_mute  <= 1'b1;
          r_busy  <= 1'b1;
        end
        default: begin
          r_sound <= CODE_NONE;
          r_mute  <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign sound = r_sound;
  assign mute  = r_mute;
  assign busy  = r_busy;

endmodule

// File: tb/tb_sound_event_seq.sv
// -----------------------------------------------------------------------------
// tb_sound_event_seq
//   Scoreboard bench for sound_event_seq with short tick parameters. Each
//   scenario pushes its expected per-edge {sound, mute, busy} trace into a
//   queue, then drives strobes and pops/compares one entry per clock edge.
// -----------------------------------------------------------------------------
module tb_sound_event_seq;

  logic       snd_clk = 1'b0;
  logic       rstn    = 1'b0;
  logic       enable  = 1'b1;
  logic       ev_ping = 1'b0;
  logic       ev_pong = 1'b0;
  logic       ev_goal = 1'b0;
  logic [1:0] sound;
  logic       mute;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] sb[$];
  logic [3:0] exp_v;
  logic [3:0] obs_v;

  sound_event_seq #(
    .PING_TICKS(8),
    .PONG_TICKS(12),
    .GOAL_TICKS(6),
    .GAP_TICKS (4),
    .GOAL_BEEPS(3)
  ) dut (
    .snd_clk(snd_clk),
    .rstn   (rstn),
    .enable (enable),
    .ev_ping(ev_ping),
    .ev_pong(ev_pong),
    .ev_goal(ev_goal),
    .sound  (sound),
    .mute   (mute),
    .busy   (busy)
  );

  always #5 snd_clk = ~snd_clk;

  // Expected trace segment: n edges of {sound, mute, busy}.
  task automatic push_seg(input logic [1:0] s, input logic m, input logic b, input int n);
    for (int i = 0; i < n; i++) sb.push_back({s, m, b});
  endtask

  // Present inputs for one edge, then wait to the following falling edge.
  task automatic cyc(input logic p, input logic q, input logic g, input logic en);
    ev_ping = p;
    ev_pong = q;
    ev_goal = g;
    enable  = en;
    @(posedge snd_clk);
    @(negedge snd_clk);
    ev_ping = 1'b0;
    ev_pong = 1'b0;
    ev_goal = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge snd_clk);
    n_checks++;
    if ({sound, mute, busy} !== 4'b0010) begin
      n_fail++;
      $display("FAIL reset_hold got=%b exp=%b", {sound, mute, busy}, 4'b0010);
    end
    rstn = 1'b1;
    push_seg(2'd0, 1'b1, 1'b0, 20);
    for (int c = 0; sb.size() > 0; c++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      exp_v = sb.pop_front();
      obs_v = {sound, mute, busy};
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL reset_idle c=%0d got=%b exp=%b", c, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_ping();
    push_seg(2'd0, 1'b1, 1'b0, 1);
    push_seg(2'd1, 1'b0, 1'b1, 8);
    push_seg(2'd0, 1'b1, 1'b1, 4);
    push_seg(2'd0, 1'b1, 1'b0, 2);
    for (int c = 0; sb.size() > 0; c++) begin
      cyc(c == 0, 1'b0, 1'b0, 1'b1);
      exp_v = sb.pop_front();
      obs_v = {sound, mute, busy};
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL ping_burst c=%0d got=%b exp=%b", c, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_goal();
    push_seg(2'd0, 1'b1, 1'b0, 1);
    for (int k = 0; k < 3; k++) begin
      push_seg(2'd3, 1'b0, 1'b1, 6);
      push_seg(2'd0, 1'b1, 1'b1, 4);
    end
    push_seg(2'd0, 1'b1, 1'b0, 2);
    for (int c = 0; sb.size() > 0; c++) begin
      cyc(1'b0, 1'b0, c == 0, 1'b1);
      exp_v = sb.pop_front();
      obs_v = {sound, mute, busy};
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL goal_seq c=%0d got=%b exp=%b", c, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_preempt();
    push_seg(2'd0, 1'b1, 1'b0, 1);
    push_seg(2'd1, 1'b0, 1'b1, 3);
    push_seg(2'd2, 1'b0, 1'b1, 12);
    push_seg(2'd0, 1'b1, 1'b1, 4);
    push_seg(2'd0, 1'b1, 1'b0, 2);
    for (int c = 0; sb.size() > 0; c++) begin
      cyc(c == 0, c == 3, 1'b0, 1'b1);
      exp_v = sb.pop_front();
      obs_v = {sound, mute, busy};
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL preempt c=%0d got=%b exp=%b", c, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_pending();
    push_seg(2'd0, 1'b1, 1'b0, 1);
    push_seg(2'd2, 1'b0, 1'b1, 12);
    push_seg(2'd0, 1'b1, 1'b1, 4);
    push_seg(2'd1, 1'b0, 1'b1, 8);
    push_seg(2'd0, 1'b1, 1'b1, 4);
    push_seg(2'd0, 1'b1, 1'b0, 2);
    for (int c = 0; sb.size() > 0; c++) begin
      cyc((c == 2) || (c == 5), c == 0, 1'b0, 1'b1);
      exp_v = sb.pop_front();
      obs_v = {sound, mute, busy};
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL pending c=%0d got=%b exp=%b", c, obs_v, exp_v);
      end
    end
  endtask

  // Pong arrives exactly as the gap of the first pong expires while a ping
  // waits: the pong wins the merge and the ping stays pending.
  task automatic test_gap_merge();
    push_seg(2'd0, 1'b1, 1'b0, 1);
    push_seg(2'd2, 1'b0, 1'b1, 12);
    push_seg(2'd0, 1'b1, 1'b1, 4);
    push_seg(2'd2, 1'b0, 1'b1, 12);
    push_seg(2'd0, 1'b1, 1'b1, 4);
    push_seg(2'd1, 1'b0, 1'b1, 8);
    push_seg(2'd0, 1'b1, 1'b1, 4);
    push_seg(2'd0, 1'b1, 1'b0, 2);
    for (int c = 0; sb.size() > 0; c++) begin
      cyc(c == 3, (c == 0) || (c == 16), 1'b0, 1'b1);
      exp_v = sb.pop_front();
      obs_v = {sound, mute, busy};
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL gap_merge c=%0d got=%b exp=%b", c, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_simultaneous();
    push_seg(2'd0, 1'b1, 1'b0, 1);
    for (int k = 0; k < 3; k++) begin
      push_seg(2'd3, 1'b0, 1'b1, 6);
      push_seg(2'd0, 1'b1, 1'b1, 4);
    end
    push_seg(2'd0, 1'b1, 1'b0, 2);
    for (int c = 0; sb.size() > 0; c++) begin
      cyc(c == 0, c == 0, c == 0, 1'b1);
      exp_v = sb.pop_front();
      obs_v = {sound, mute, busy};
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL simultaneous c=%0d got=%b exp=%b", c, obs_v, exp_v);
      end
    end
  endtask

  // Disable during the first goal gap; a ping while disabled is ignored and
  // nothing resumes once enable returns.
  task automatic test_enable_abort();
    push_seg(2'd0, 1'b1, 1'b0, 1);
    push_seg(2'd3, 1'b0, 1'b1, 6);
    push_seg(2'd0, 1'b1, 1'b1, 1);
    push_seg(2'd0, 1'b1, 1'b0, 13);
    for (int c = 0; sb.size() > 0; c++) begin
      cyc(c == 9, 1'b0, c == 0, !((c >= 8) && (c <= 10)));
      exp_v = sb.pop_front();
      obs_v = {sound, mute, busy};
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL enable_abort c=%0d got=%b exp=%b", c, obs_v, exp_v);
      end
    end
  endtask

  // Reset in the middle of a pong with a ping pending: immediate silence and
  // no replay of the pending ping after release.
  task automatic test_reset_mid();
    push_seg(2'd0, 1'b1, 1'b0, 1);
    push_seg(2'd2, 1'b0, 1'b1, 5);
    for (int c = 0; sb.size() > 0; c++) begin
      cyc(c == 3, c == 0, 1'b0, 1'b1);
      exp_v = sb.pop_front();
      obs_v = {sound, mute, busy};
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL reset_mid_pre c=%0d got=%b exp=%b", c, obs_v, exp_v);
      end
    end
    #2 rstn = 1'b0;
    #1;
    n_checks++;
    if ({sound, mute, busy} !== 4'b0010) begin
      n_fail++;
      $display("FAIL reset_mid_async got=%b exp=%b", {sound, mute, busy}, 4'b0010);
    end
    @(negedge snd_clk);
    rstn = 1'b1;
    push_seg(2'd0, 1'b1, 1'b0, 30);
    for (int c = 0; sb.size() > 0; c++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      exp_v = sb.pop_front();
      obs_v = {sound, mute, busy};
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL reset_mid_post c=%0d got=%b exp=%b", c, obs_v, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ping();
    test_goal();
    test_preempt();
    test_pending();
    test_gap_merge();
    test_simultaneous();
    test_enable_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
